// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter selector and PC register.
package pc_pkg;

  typedef enum logic {
    RUN = 1'b0,
    EXC = 1'b1
  } pc_state_t;

  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;
  localparam logic [1:0] CAUSE_DIV0   = 2'd2;

  localparam logic [31:0] DEFAULT_EXC_VEC = 32'h0000_00FC;

endpackage

// File: rtl/pc_src_mux.sv
// Parametrised N-way combinational selector over a packed source bus.
// Reports whether the select index addresses a real source.
module pc_src_mux #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 8,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       data,
  output logic                   sel_valid
);

  // One extra bit so N_SRC itself is representable when N_SRC is a power of two.
  localparam logic [SEL_W:0] N_SRC_L = (SEL_W + 1)'(N_SRC);

  assign sel_valid = ({1'b0, sel} < N_SRC_L);

  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel == SEL_W'(k)) data = src_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pc_select_reg.sv
// Registered program counter with N-way source select, branch-conditional
// writes, exception entry (EPC/cause capture) and return-from-exception.
module pc_select_reg
  import pc_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              N_SRC     = 8,
  parameter int              SEL_W     = $clog2(N_SRC),
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = DEFAULT_EXC_VEC,
  parameter int              PC_INC    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]       pc_sel,
  input  logic                   pc_write,
  input  logic                   pc_write_cond,
  input  logic                   cond_true,
  input  logic                   exc_req,
  input  logic [1:0]             exc_cause,
  input  logic                   eret,
  output logic [WIDTH-1:0]       pc_out,
  output logic [WIDTH-1:0]       epc_out,
  output logic [1:0]             cause_out,
  output logic                   in_exc,
  output logic                   pc_loaded,
  output logic                   misaligned,
  output logic                   sel_err
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, load_val, mux_data;
  logic [1:0]       cause_q, cause_d;
  logic             loaded_q, loaded_d, mis_q, mis_d, sel_err_q, sel_err_d;
  logic             we, load, sel_valid;

  pc_src_mux #(
    .WIDTH (WIDTH),
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_mux (
    .src_data  (src_data),
    .sel       (pc_sel),
    .data      (mux_data),
    .sel_valid (sel_valid)
  );

  assign we = pc_write | (pc_write_cond & cond_true);

  // Exception entry beats eret, which beats a normal write; the losers are dropped.
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    sel_err_d = sel_err_q;
    load      = 1'b0;
    load_val  = pc_q;
    if (state_q == RUN && exc_req) begin
      epc_d    = pc_q - WIDTH'(PC_INC);
      cause_d  = exc_cause;
      load_val = EXC_VEC;
      load     = 1'b1;
      state_d  = EXC;
    end else if (state_q == EXC && eret) begin
      load_val = epc_q;
      load     = 1'b1;
      state_d  = RUN;
    end else if (we) begin
      if (sel_valid) begin
        load_val = mux_data;
        load     = 1'b1;
      end else begin
        sel_err_d = 1'b1;
      end
    end
    pc_d     = load ? load_val : pc_q;
    loaded_d = load;
    mis_d    = load & (|load_val[1:0]);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      cause_q   <= '0;
      loaded_q  <= 1'b0;
      mis_q     <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      loaded_q  <= loaded_d;
      mis_q     <= mis_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign pc_out     = pc_q;
  assign epc_out    = epc_q;
  assign cause_out  = cause_q;
  assign in_exc     = (state_q == EXC);
  assign pc_loaded  = loaded_q;
  assign misaligned = mis_q;
  assign sel_err    = sel_err_q;

endmodule

// File: doc/pc_select_reg.md
# pc_select_reg

Parametrised program-counter source selector and PC register for the multicycle datapath. It replaces the fixed 7-way combinational PC mux with an N-way selector feeding a registered PC. The PC register supports unconditional and branch-conditional writes. Exception entry captures EPC and cause, and return-from-exception restores the PC. It sits between the ALU/shift/memory outputs and the instruction-fetch address path and is driven by the control unit.

## Interface
- `WIDTH`, 32: data/PC width in bits.
- `N_SRC`, 8: number of PC source inputs, 2..16.
- `SEL_W`, $clog2(N_SRC): select width.
- `RESET_VEC`, 0: PC value after reset.
- `EXC_VEC`, 32'h0000_00FC: PC loaded on exception entry.
- `PC_INC`, 4: offset subtracted from the PC when forming EPC.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `src_data` in N_SRC*WIDTH: packed sources; source k is bits [k*WIDTH +: WIDTH].
- `pc_sel` in SEL_W: source index.
- `pc_write` in 1: unconditional PC write.
- `pc_write_cond` in 1: branch write; effective only when `cond_true` is 1.
- `cond_true` in 1: branch condition, e.g. ALU zero or its inverse, chosen upstream.
- `exc_req` in 1: exception request, level-sampled.
- `exc_cause` in 2: cause code sampled with `exc_req`.
- `eret` in 1: return from exception.
- `pc_out` out WIDTH: current PC.
- `epc_out` out WIDTH: saved exception PC.
- `cause_out` out 2: saved cause.
- `in_exc` out 1: 1 while in state EXC.
- `pc_loaded` out 1: one-cycle pulse in the cycle after any PC update.
- `misaligned` out 1: one-cycle pulse when the value just loaded has bits [1:0] ≠ 0.
- `sel_err` out 1: sticky flag, set when a write is attempted with `pc_sel` ≥ N_SRC.

## Operation
- States: RUN (reset state) and EXC.
- Effective write: `we = pc_write | (pc_write_cond & cond_true)`.
- Priority per cycle, highest first:
  1. `reset`: PC ← RESET_VEC, EPC ← 0, cause ← 0, state RUN, all flags 0.
  2. RUN & `exc_req`:
     - EPC ← PC − PC_INC, modulo 2^WIDTH; wraps when PC < PC_INC.
     - cause ← `exc_cause`, PC ← EXC_VEC, state → EXC.
     - A same-cycle `we` is discarded.
  3. EXC & `eret`: PC ← EPC, state → RUN. A same-cycle `we` is discarded.
  4. `we` and `pc_sel` < N_SRC: PC ← selected source. Allowed in both states so the handler can fetch.
  5. `we` and `pc_sel` ≥ N_SRC: PC holds, `sel_err` ← 1. The flag clears only on reset.
- `exc_req` in EXC: ignored. No nesting; EPC and cause hold.
- `eret` in RUN: ignored.
- `pc_loaded`: registered; 1 in the cycle after cases 2, 3 and 4, else 0.
- `misaligned`: registered; evaluated on the value loaded in cases 2, 3 and 4. The load still happens.

## Timing
- Latency: selection is combinational; PC, EPC, cause, state and all flags are registered. A write in cycle n is visible on `pc_out` in cycle n+1.
- Same-cycle read: source value changes in cycle n never affect `pc_out` before n+1.
- No handshake: the control unit must hold `exc_req` only for the sampling cycle. Holding it longer is harmless, because EXC ignores it.
- Reset mid-exception: returns to RUN with EPC = 0, regardless of pending `eret`.
- Reset values: `pc_out` = RESET_VEC; `epc_out`, `cause_out`, `in_exc`, `pc_loaded`, `misaligned`, `sel_err` = 0.

## Structure
- Shared package `pc_pkg`:
  - state enum `pc_state_t {RUN, EXC}`;
  - cause constants `CAUSE_OPCODE=2'd0`, `CAUSE_OVF=2'd1`, `CAUSE_DIV0=2'd2`;
  - default `EXC_VEC`.
- Sub-module `pc_src_mux`: parametrised N_SRC×WIDTH combinational selector that also outputs `sel_valid`. It is reused for other datapath muxes.
- Top-level module holds the registers and the state machine.

## Test plan
- Reset, then `pc_write`=1, `pc_sel`=1, src1=0x0000_0040 → `pc_out`=0x40 next cycle; `pc_loaded` pulses once; `misaligned`=0.
- `pc_write_cond`=1 with `cond_true`=0, src2=0x80 → PC holds at 0x40. Repeat with `cond_true`=1 → PC=0x80.
- PC=0x104, `exc_req`=1 with cause 1 and simultaneous `pc_write` → PC=EXC_VEC, `epc_out`=0x100, `cause_out`=1, `in_exc`=1.
  - Second `exc_req` with cause 2 → EPC and cause unchanged.
- In EXC, `pc_write` to 0x200, then `eret` → PC=0x200, then 0x100; `in_exc`=0.
- N_SRC=6, `pc_write` with `pc_sel`=7 → PC holds, `sel_err`=1 and stays set.
  - Load 0x0000_0042 → `misaligned` pulses once.
- PC=0x0, `exc_req` → EPC=0xFFFF_FFFC (wrap).
  - Reset asserted in EXC alongside `eret` → PC=RESET_VEC, state RUN, EPC=0.
